// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: one-directional stage link; master drives valid/ctrl/data/pc/rd/rt, slave drives ready
interface pipe_stage_reg_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 12,
  parameter int REG_W  = 4
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] pc;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rt;
  modport master (output valid, ctrl, data, pc, rd, rt, input ready);
  modport slave  (input valid, ctrl, data, pc, rd, rt, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic stage register (clk, rst async active-low, flush, up slave link, dn master link, occupancy) with optional skid entry
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 12,
  parameter int REG_W  = 4,
  parameter int SKID   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_reg_if.slave       up,
  pipe_stage_reg_if.master      dn,
  output logic [1:0]            occupancy
);
  localparam int PW = CTRL_W + 2*DATA_W + 2*REG_W;
  logic [PW-1:0] m_q, s_q, in_w;
  logic m_v, s_v, rdy, xin, xout, m_load, s_load, m_v_n, s_v_n;
  assign in_w = {up.ctrl, up.data, up.pc, up.rd, up.rt};
  assign up.ready = (SKID != 0) ? rdy : (dn.ready | !m_v);
  assign xin = up.valid & up.ready;
  assign xout = m_v & dn.ready;
  always_comb begin
    m_load = !flush && (!m_v || xout) && (s_v || xin);
    s_load = (SKID != 0) && !flush && xin && m_v && !xout && !s_v;
    m_v_n  = !flush && ((!m_v || xout) ? (s_v || xin) : 1'b1);
    s_v_n  = (SKID != 0) && !flush && (s_v ? !xout : (xin && m_v && !xout));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      rdy <= 1'b1;
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_v <= m_v_n;
      s_v <= s_v_n;
      rdy <= !s_v_n;
      if (m_load) m_q <= s_v ? s_q : in_w;
      if (s_load) s_q <= in_w;
    end
  end
  assign dn.valid  = m_v;
  assign dn.ctrl   = m_v ? m_q[PW-1 -: CTRL_W] : '0;
  assign dn.data   = m_q[2*REG_W+2*DATA_W-1 -: DATA_W];
  assign dn.pc     = m_q[2*REG_W+DATA_W-1 -: DATA_W];
  assign dn.rd     = m_q[2*REG_W-1 -: REG_W];
  assign dn.rt     = m_q[REG_W-1:0];
  assign occupancy = {1'b0, m_v} + {1'b0, s_v};
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register, successor to the fixed always-enabled inter-stage flop banks (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control-bit vector, two data words and two register specifiers between stages.
- Adds a valid/ready handshake, stall (backpressure), flush (bubble insertion) and an optional 2-entry skid buffer so upstream ready is fully registered.
- One instance per stage boundary replaces each hand-built register bank.

Parameters:
DATA_W, 16, width of in_data/out_data and in_pc/out_pc
CTRL_W, 12, width of the control-bit vector
REG_W, 4, width of each register specifier
SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = one entry with combinational in_ready

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  control bits (RegWrite, MemRead, MemWrite, HLT, ...)
in_data  in  DATA_W  primary data (ALU result)
in_pc  in  DATA_W  PC of the instruction
in_rd  in  REG_W  destination register
in_rt  in  REG_W  second source register
flush  in  1  synchronous kill of all held entries
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts this cycle
out_ctrl  out  CTRL_W  control bits; all zero whenever out_valid=0
out_data  out  DATA_W  held data
out_pc  out  DATA_W  held PC
out_rd  out  REG_W  held rd
out_rt  out  REG_W  held rt
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst low, async): both entries invalid; out_ctrl, out_data, out_pc, out_rd, out_rt = 0; out_valid = 0; occupancy = 0; in_ready = 1 on the first cycle after release.
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready. Both evaluated at the same edge.
- SKID=1 states, main M and skid S:
  - EMPTY: in -> ONE; in_ready = 1.
  - ONE: in & out -> ONE (M takes new); in & !out -> TWO (new goes to S); !in & out -> EMPTY.
  - TWO: in_ready = 0; out -> ONE (S moves to M); otherwise hold.
  - in_ready is a flop output: 1 exactly when state != TWO.
- SKID=0: single entry; in_ready = out_ready | !out_valid (combinational); occupancy is 0 or 1.
- Latency: 1 cycle in -> out when the stage is empty. Full throughput, 1 transfer per cycle, whenever out_ready = 1.
- Order: strict FIFO. The skid entry is never presented before the main entry.
- Stall (out_ready = 0): all held fields remain bit-stable. No entry is dropped or duplicated.
- Flush: sets state to EMPTY at the next edge.
  - Flush has priority over a same-cycle in transfer; that input is discarded.
  - A same-cycle out transfer still completes downstream, but nothing replaces it.
  - After flush, out_valid = 0 and out_ctrl = 0 (bubble). Data, pc, rd and rt keep their last values; they are don't-care.
- Bubble safety: out_ctrl is gated with out_valid, so a downstream stage that ignores valid sees a NOP.
- Reset asserted mid-operation: immediate clear regardless of clk. No partial state survives.
- All widths pass through unchanged. No arithmetic on the data path; occupancy saturates at 2 by construction.

Test Plan:
1. Reset then stream: drive in_valid=1 with out_ready=1 and in_data = 0x0001, 0x0002, 0x0003 on consecutive cycles -> out_data = 0x0001, 0x0002, 0x0003 one cycle later each; occupancy = 1 throughout; in_ready stays 1.
2. Backpressure (SKID=1): hold out_ready=0, send 0x00A1 and 0x00A2 -> occupancy = 2, in_ready = 0 on the following cycle. Raise out_ready -> out_data = 0x00A1 then 0x00A2, with no loss or duplication.
3. Flush in TWO with in_valid=1 (in_data = 0x00FF) -> next cycle out_valid = 0, out_ctrl = 0x000, occupancy = 0; 0x00FF never appears at the output.
4. Async reset: assert rst low between clock edges while occupancy = 2 -> all outputs 0 immediately, before the next edge; in_ready = 1 after release.
5. SKID=0 build: out_ready=0 with one entry held -> in_ready = 0 in the same cycle. Set out_ready=1 and in_valid=1 together (in_data = 0x0B0B) -> the held entry leaves and 0x0B0B is captured at that edge.
6. Stall hold: out_ready=0 for 5 cycles with in_ctrl and in_data toggling -> out_ctrl, out_data, out_pc, out_rd and out_rt stay bit-identical for all 5 cycles.
